// File: rtl/uart_pkg.sv
// Shared UART definitions: sender FSM state encodings and default
// clock/baud constants used by the transmitter, receiver and TX FIFO.
package uart_pkg;

  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = 115_200;

  // Sender FSM states for the TX FIFO front end.
  typedef enum logic [1:0] {
    sIDLE  = 2'd0,
    sSTART = 2'd1,
    sWAIT  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with AW+1 bit pointers; the pointer MSB is the wrap
// flag that tells full from empty when the low bits match.
// Optional macro UART_TX_FIFO_LEVEL_EN adds the o_level occupancy output.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [AW:0]      o_level,
`endif
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_push;
  logic             w_pop;

  // Pushes while full and pops while empty are dropped here as well.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
  assign o_data  = r_mem[r_rd[AW-1:0]];
`ifdef UART_TX_FIFO_LEVEL_EN
  assign o_level = r_wr - r_rd;
`endif

  // Storage write; contents are not reset, the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= i_data;
    end
  end

  // Pointer update; both move on a simultaneous push and pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte-buffering front end for the UART transmitter: valid/ready input into
// a FIFO, then one start pulse per byte paced by the transmitter busy/done.
// Optional macro UART_TX_FIFO_LEVEL_EN adds the oLevel occupancy port.
//
// Handshake: a byte is accepted on a rising edge where iValid && oReady;
// oReady is !oFull and is the only combinational output. iData must hold
// while iValid is high and oReady is low.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oReady,
  output logic       oTxStart,
  output logic [7:0] oTxByte,
  input  logic       iTxBusy,
  input  logic       iTxDone,
  output logic       oEmpty,
  output logic       oFull,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [AW:0] oLevel,
`endif
  output tx_state_e  oDbgState
);

  tx_state_e  r_state;
  tx_state_e  w_state_next;
  logic       w_pop;
  logic       w_push;
  logic [7:0] w_fifo_data;
  logic [7:0] r_tx_byte;

  assign oReady    = !oFull;
  assign w_push    = iValid && oReady;
  assign oTxStart  = (r_state == sSTART);
  assign oTxByte   = r_tx_byte;
  assign oDbgState = r_state;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (iClk),
    .i_rst   (iRst),
    .i_push  (w_push),
    .i_data  (iData),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
`ifdef UART_TX_FIFO_LEVEL_EN
    .o_level (oLevel),
`endif
    .o_empty (oEmpty),
    .o_full  (oFull)
  );

  // Sender next-state: pop only when leaving idle, done only counts in wait.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      sIDLE: begin
        if (!oEmpty && !iTxBusy) begin
          w_pop        = 1'b1;
          w_state_next = sSTART;
        end
      end
      sSTART:  w_state_next = sWAIT;
      sWAIT:   if (iTxDone) w_state_next = sIDLE;
      default: w_state_next = sIDLE;
    endcase
  end

  // Sender state register.
  always_ff @(posedge iClk) begin
    if (iRst) r_state <= sIDLE;
    else      r_state <= w_state_next;
  end

  // Byte register captured at pop; held until the next pop.
  always_ff @(posedge iClk) begin
    if (iRst)       r_tx_byte <= 8'h00;
    else if (w_pop) r_tx_byte <= w_fifo_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (DEPTH=16): vector table for the
// single-byte path, plus sequences for bursts, full, wrap, push+pop, reset.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic [7:0] iData = 8'h00;
  logic       iValid = 1'b0;
  logic       oReady;
  logic       oTxStart;
  logic [7:0] oTxByte;
  logic       iTxBusy;
  logic       iTxDone;
  logic       oEmpty;
  logic       oFull;
  logic [4:0] oLevel;
  tx_state_e  oDbgState;

  logic       v_busy = 1'b0;
  logic       v_done = 1'b0;
  logic       m_en = 1'b0;
  logic       m_busy;
  logic       m_done;
  logic [3:0] m_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int last_done = 0;
  bit have_done = 0;
  bit check_gap = 0;
  bit sb_en = 0;
  logic [7:0] exp_q[$];

  assign iTxBusy = m_busy | v_busy;
  assign iTxDone = m_done | v_done;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iData     (iData),
    .iValid    (iValid),
    .oReady    (oReady),
    .oTxStart  (oTxStart),
    .oTxByte   (oTxByte),
    .iTxBusy   (iTxBusy),
    .iTxDone   (iTxDone),
    .oEmpty    (oEmpty),
    .oFull     (oFull),
`ifdef UART_TX_FIFO_LEVEL_EN
    .oLevel    (oLevel),
`endif
    .oDbgState (oDbgState)
  );

`ifndef UART_TX_FIFO_LEVEL_EN
  assign oLevel = 5'd0;
`endif

  // ---------------- clock ----------------
  always #5 iClk = ~iClk;

  // Transmitter model: busy for 10 cycles after a start, then a 1-cycle done.
  always @(posedge iClk) begin
    if (iRst || !m_en) begin
      m_busy <= 1'b0; m_cnt <= 4'd0; m_done <= 1'b0;
    end else if (oTxStart) begin
      m_busy <= 1'b1; m_cnt <= 4'd10; m_done <= 1'b0;
    end else if (m_cnt != 4'd0) begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1) begin m_busy <= 1'b0; m_done <= 1'b1; end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every start pulse must carry the oldest expected byte.
  always begin
    @(posedge iClk);
    #1;
    cyc++;
    if (sb_en) begin
      if (iTxDone) begin last_done = cyc; have_done = 1; end
      if (oTxStart) begin
        starts++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: got byte %0h expected no start", oTxByte);
        end else begin
          chk("tx_byte", {24'd0, oTxByte}, {24'd0, exp_q.pop_front()});
        end
        if (check_gap && have_done) chk("frame_gap", cyc - last_done, 2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    sb_en = 0; m_en = 0; check_gap = 0; have_done = 0;
    iRst = 1'b1; iValid = 1'b0; v_busy = 1'b0; v_done = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    int tries = 0;
    iData = b; iValid = 1'b1;
    while (!oReady && tries < 400) begin @(posedge iClk); #1; tries++; end
    if (!oReady) begin
      chk("push_ready_timeout", {31'd0, oReady}, 1);
    end else begin
      @(posedge iClk); #1;
      exp_q.push_back(b);
    end
    iValid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
      @(posedge iClk); #1;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       exp_start;
    logic [7:0] exp_byte;
    logic       exp_empty;
    logic       exp_full;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[13];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0;
    //            push data   busy done  start byte   empty full state
    vecs[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 2'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 2'd2};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 2'd1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 2'd2};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h66, 1'b1, 1'b0, 2'd2};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 2'd0};
    vecs[11] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 2'd1};

    // ---- reset values ----
    do_reset();
    chk("rst_start", {31'd0, oTxStart}, 0);
    chk("rst_byte", {24'd0, oTxByte}, 0);
    chk("rst_empty", {31'd0, oEmpty}, 1);
    chk("rst_full", {31'd0, oFull}, 0);
    chk("rst_ready", {31'd0, oReady}, 1);
    chk("rst_state", {30'd0, oDbgState}, {30'd0, sIDLE});
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("rst_level", {27'd0, oLevel}, 0);
`endif

    // ---- single-byte path from the vector table ----
    for (int i = 0; i < 13; i++) begin
      iValid = vecs[i].push; iData = vecs[i].data;
      v_busy = vecs[i].busy; v_done = vecs[i].done;
      @(posedge iClk); #1;
      iValid = 1'b0; v_done = 1'b0;
      chk($sformatf("vec%0d_start", i), {31'd0, oTxStart}, {31'd0, vecs[i].exp_start});
      chk($sformatf("vec%0d_byte", i), {24'd0, oTxByte}, {24'd0, vecs[i].exp_byte});
      chk($sformatf("vec%0d_empty", i), {31'd0, oEmpty}, {31'd0, vecs[i].exp_empty});
      chk($sformatf("vec%0d_full", i), {31'd0, oFull}, {31'd0, vecs[i].exp_full});
      chk($sformatf("vec%0d_state", i), {30'd0, oDbgState}, {30'd0, vecs[i].exp_state});
    end

    // ---- three back-to-back bytes with modelled transmitter ----
    do_reset();
    m_en = 1; sb_en = 1; check_gap = 1;
    s0 = starts;
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    wait_drain(200);
    chk("burst3_starts", starts - s0, 3);

    // ---- fill to full with transmitter busy ----
    do_reset();
    v_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i + 16));
    chk("full_flag", {31'd0, oFull}, 1);
    chk("full_ready", {31'd0, oReady}, 0);
    chk("full_empty", {31'd0, oEmpty}, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("full_level", {27'd0, oLevel}, 16);
`endif
    iData = 8'hEE; iValid = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    chk("full_17th_full", {31'd0, oFull}, 1);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("full_17th_level", {27'd0, oLevel}, 16);
`endif
    sb_en = 1; m_en = 1; v_busy = 1'b0;
    s0 = starts;
    wait_drain(400);
    repeat (30) @(posedge iClk);
    #1;
    chk("full_drain_starts", starts - s0, 16);
    chk("full_drain_empty", {31'd0, oEmpty}, 1);

    // ---- pointer wrap: 40 bytes through a 16-deep FIFO ----
    do_reset();
    m_en = 1; sb_en = 1;
    s0 = starts;
    for (int i = 0; i < 40; i++) push_byte(8'(i * 7 + 3));
    wait_drain(1000);
    chk("wrap_starts", starts - s0, 40);

    // ---- simultaneous push and pop at level 5 ----
    do_reset();
    v_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("pp_level_before", {27'd0, oLevel}, 5);
`endif
    sb_en = 1;
    s0 = starts;
    iData = 8'h99; iValid = 1'b1; v_busy = 1'b0;
    @(posedge iClk); #1;
    iValid = 1'b0;
    exp_q.push_back(8'h99);
    chk("pp_start", {31'd0, oTxStart}, 1);
    chk("pp_empty", {31'd0, oEmpty}, 0);
    chk("pp_full", {31'd0, oFull}, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("pp_level_after", {27'd0, oLevel}, 5);
`endif
    m_en = 1;
    wait_drain(400);
    chk("pp_total_starts", starts - s0, 6);

    // ---- reset while waiting with 4 bytes queued ----
    do_reset();
    m_en = 1; sb_en = 1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'hD0 + i));
    chk("rw_state_wait", {30'd0, oDbgState}, {30'd0, sWAIT});
    chk("rw_queued", exp_q.size(), 4);
    iRst = 1'b1;
    @(posedge iClk); #1;
    exp_q.delete();
    chk("rw_state_idle", {30'd0, oDbgState}, {30'd0, sIDLE});
    chk("rw_empty", {31'd0, oEmpty}, 1);
    chk("rw_start", {31'd0, oTxStart}, 0);
    chk("rw_byte", {24'd0, oTxByte}, 0);
    iRst = 1'b0;
    s0 = starts;
    repeat (20) @(posedge iClk);
    #1;
    chk("rw_no_start", starts - s0, 0);
    push_byte(8'h3C);
    @(posedge iClk); #1;
    chk("rw_new_start", {31'd0, oTxStart}, 1);
    chk("rw_new_byte", {24'd0, oTxByte}, 8'h3C);
    wait_drain(50);

    sb_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
